serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand pair valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port a  input  WIDTH  minuend, unsigned/two's complement.
REQ-007 SHALL have port b  input  WIDTH  subtrahend.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port diff  output  WIDTH  a minus b, modulo 2^WIDTH.
REQ-011 SHALL have port borrow  output  1  final borrow; 1 when unsigned a < b.
REQ-012 SHALL have port ovf  output  1  signed overflow flag, present only per REQ-027.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL, in IDLE when in_valid&in_ready, capture a and b into shift registers, clear the borrow flop, clear the bit counter and enter RUN; a and b are ignored at all other times.
REQ-016 SHALL, in each RUN cycle, process exactly one bit, LSB first: d = a0^b0^bin; bout = (~a0&b0) | (~(a0^b0)&bin); shift d into diff MSB-side; register bout.
REQ-017 SHALL count RUN cycles 0..WIDTH-1 and go to DONE after the cycle with count WIDTH-1.
REQ-018 SHALL assert out_valid exactly WIDTH+1 rising edges after the accepting edge.
REQ-019 SHALL hold diff, borrow and ovf stable in DONE until out_valid&out_ready; then enter IDLE, so in_ready is 1 on the following cycle.
REQ-020 SHALL not overlap operations; throughput is at most one result per WIDTH+2 cycles.
REQ-021 SHALL keep out_valid asserted indefinitely while out_ready=0, with no loss or change of the result.
REQ-022 SHALL produce borrow = 1 for a=0 and b=0 only if a<b; 0-0 gives diff=0 and borrow=0.

Reset
REQ-023 SHALL, when rst=1 at a rising edge, enter IDLE and clear the counter, shift registers, diff, borrow and ovf to 0, with in_ready=1 and out_valid=0 from the next cycle.
REQ-024 SHALL abort any RUN or DONE operation on reset; the aborted result is never presented.
REQ-025 SHALL let reset override a simultaneous in_valid handshake; the operands are not captured.

Configuration
REQ-026 SHALL use macro SERIAL_SUB_OVF_EN.
REQ-027 SHALL, with SERIAL_SUB_OVF_EN defined, provide port ovf = (a[MSB]!=b[MSB]) & (diff[MSB]!=a[MSB]), registered with diff; without the macro, port ovf and its logic are absent.

Structure
REQ-028 SHALL take state encoding (IDLE=0, RUN=1, DONE=2, 2 bits) and the default WIDTH constant from shared package serial_sub_pkg.
REQ-029 SHALL instantiate the one-bit combinational cell as sub-module full_subtractor (inputs Ai, Bi, Bin; outputs Do, Bo).

Verification
REQ-030 SHALL cover a=8'd5, b=8'd3, out_ready=1 -> diff=8'd2, borrow=0, out_valid on handshake edge +9.
REQ-031 SHALL cover a=8'd3, b=8'd5 -> diff=8'hFE, borrow=1.
REQ-032 SHALL cover a=8'h80, b=8'h01 -> diff=8'h7F, borrow=0, ovf=1 with the macro defined.
REQ-033 SHALL cover a=8'h0F, b=8'h0F with out_ready=0 held for 5 cycles after out_valid -> diff=0 stable, in_ready=0 throughout; in_ready=1 the cycle after out_ready rises.
REQ-034 SHALL cover rst=1 asserted at RUN count 3 -> IDLE next cycle, out_valid never asserted; a new pair 8'd9-8'd4 then gives diff=8'd5.
REQ-035 SHALL cover in_valid held high across back-to-back pairs -> second pair accepted only in IDLE, with results in order and none dropped.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg -- shared constants and types for the bit-serial subtractor.
//   state_t       : FSM encoding (IDLE=0, RUN=1, DONE=2), 2 bits
//   DEFAULT_WIDTH : default operand/result width
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor -- one-bit combinational subtractor cell.
//   Ai, Bi : minuend / subtrahend bit
//   Bin    : borrow in
//   Do     : difference bit
//   Bo     : borrow out
module full_subtractor (
  input  logic Ai,
  input  logic Bi,
  input  logic Bin,
  output logic Do,
  output logic Bo
);

  assign Do = Ai ^ Bi ^ Bin;
  // Borrow when the minuend bit is 0 and the subtrahend bit is 1, or when the
  // bits are equal and a borrow is already pending.
  assign Bo = (~Ai & Bi) | (~(Ai ^ Bi) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor -- bit-serial a - b, LSB first, one bit per clock.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand pair handshake (a, b captured on accept)
//   out_valid / out_ready: result handshake; diff/borrow/ovf held until taken
//   diff                 : a - b modulo 2^WIDTH
//   borrow               : 1 when unsigned a < b
//   ovf                  : signed overflow, only when SERIAL_SUB_OVF_EN is defined
// Results appear WIDTH+1 rising edges after the accepting edge: WIDTH RUN
// cycles followed by one DONE cycle that loads the registered output stage.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  diff_sh_q, diff_sh_d;
  logic              bor_q, bor_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              borrow_q, borrow_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              d_s, bo_s;
`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted out during RUN, so they are kept aside.
  logic              a_msb_q, a_msb_d;
  logic              b_msb_q, b_msb_d;
  logic              ovf_q, ovf_d;
`endif

  full_subtractor u_cell (
    .Ai  (a_sh_q[0]),
    .Bi  (b_sh_q[0]),
    .Bin (bor_q),
    .Do  (d_s),
    .Bo  (bo_s)
  );

  // Next-state, datapath and output-stage logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    diff_sh_d   = diff_sh_q;
    bor_d       = bor_q;
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    out_valid_d = out_valid_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d    = a;
          b_sh_d    = b;
          diff_sh_d = '0;
          bor_d     = 1'b0;
          cnt_d     = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d   = a[WIDTH-1];
          b_msb_d   = b[WIDTH-1];
`endif
          state_d   = RUN;
        end else begin
          state_d   = IDLE;
        end
      end
      RUN: begin
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        diff_sh_d = {d_s, diff_sh_q[WIDTH-1:1]};
        bor_d     = bo_s;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // First DONE cycle loads the output stage; afterwards hold until taken.
        if (!out_valid_q) begin
          diff_d      = diff_sh_q;
          borrow_d    = bor_q;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d       = (a_msb_q != b_msb_q) & (diff_sh_q[WIDTH-1] != a_msb_q);
`endif
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      diff_sh_q   <= '0;
      bor_q       <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      diff_sh_q   <= diff_sh_d;
      bor_q       <= bor_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
